// File: rtl/ay_psg_if.sv
// User-port side bus of the AY-3-8910 responder: command lines, data bus, I/O pins and
// event/status signals. The port side drives commands; the chip side answers.
interface ay_psg_if;
  logic [7:0] da_in;
  logic       ay_inact;
  logic       ay_laddr;
  logic       ay_wrpsg;
  logic       ay_rdpsg;
  logic [7:0] ioa_in;
  logic [7:0] iob_in;
  logic [7:0] da_out;
  logic       da_oe;
  logic [3:0] reg_addr;
  logic       selected;
  logic       wr_strobe;
  logic [7:0] wr_data;
  logic       env_restart;
  logic [7:0] ioa_out;
  logic [7:0] iob_out;
  logic       ioa_oe;
  logic       iob_oe;
  logic       cmd_err;

  modport master (
    output da_in, ay_inact, ay_laddr, ay_wrpsg, ay_rdpsg, ioa_in, iob_in,
    input  da_out, da_oe, reg_addr, selected, wr_strobe, wr_data, env_restart,
           ioa_out, iob_out, ioa_oe, iob_oe, cmd_err
  );

  modport slave (
    input  da_in, ay_inact, ay_laddr, ay_wrpsg, ay_rdpsg, ioa_in, iob_in,
    output da_out, da_oe, reg_addr, selected, wr_strobe, wr_data, env_restart,
           ioa_out, iob_out, ioa_oe, iob_oe, cmd_err
  );
endinterface

// File: rtl/ay_psg_responder.sv
// AY-3-8910 chip-side responder: synchronizes user-port commands, keeps the 16-entry PSG
// register file and answers latch/write/read with registered outputs and event pulses.
module ay_psg_responder #(
  parameter logic [3:0] CHIP_ID    = 4'h0,
  parameter bit         ADDR_CHECK = 1'b1
) (
  input logic     clk,
  input logic     rst,
  ay_psg_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, LATCH = 2'd1, WRITE = 2'd2, READ = 2'd3} state_t;

  // Writable bits per register; unimplemented high bits always read back as zero.
  function automatic logic [7:0] reg_mask(input logic [3:0] addr);
    logic [7:0] m;
    case (addr)
      4'd1, 4'd3, 4'd5, 4'd13:  m = 8'h0F;
      4'd6, 4'd8, 4'd9, 4'd10:  m = 8'h1F;
      default:                  m = 8'hFF;
    endcase
    return m;
  endfunction

  logic [3:0] cmd_s1_r, cmd_s2_r;
  logic [7:0] da_s1_r, da_s2_r;
  logic [7:0] ioa_s1_r, ioa_s2_r;
  logic [7:0] iob_s1_r, iob_s2_r;

  state_t     state_r, state_nx_s;
  logic [3:0] code_r, code_nx_s;
  logic       do_latch_s, do_write_s, err_s;
  logic       sel_ok_s;
  logic [7:0] wr_val_s, rd_val_s;

  logic [7:0] regs_r [16];
  logic [3:0] reg_addr_r;
  logic       selected_r;
  logic [7:0] da_out_r;
  logic       da_oe_r;
  logic       wr_strobe_r;
  logic [7:0] wr_data_r;
  logic       env_restart_r;
  logic       cmd_err_r;

  // Two-flop synchronizers for the command lines, data bus and I/O pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_s1_r <= 4'h0;
      cmd_s2_r <= 4'h0;
      da_s1_r  <= 8'h00;
      da_s2_r  <= 8'h00;
      ioa_s1_r <= 8'h00;
      ioa_s2_r <= 8'h00;
      iob_s1_r <= 8'h00;
      iob_s2_r <= 8'h00;
    end else begin
      cmd_s1_r <= {bus.ay_inact, bus.ay_laddr, bus.ay_wrpsg, bus.ay_rdpsg};
      cmd_s2_r <= cmd_s1_r;
      da_s1_r  <= bus.da_in;
      da_s2_r  <= da_s1_r;
      ioa_s1_r <= bus.ioa_in;
      ioa_s2_r <= ioa_s1_r;
      iob_s1_r <= bus.iob_in;
      iob_s2_r <= iob_s1_r;
    end
  end

  // State and last-accepted command code; the code lets a held command act only once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      code_r  <= 4'h0;
    end else begin
      state_r <= state_nx_s;
      code_r  <= code_nx_s;
    end
  end

  // Next-state decode: a code counts once it agrees across both sync stages and is new
  always_comb begin
    state_nx_s = state_r;
    code_nx_s  = code_r;
    do_latch_s = 1'b0;
    do_write_s = 1'b0;
    err_s      = 1'b0;
    if ((cmd_s1_r == cmd_s2_r) && (cmd_s2_r != code_r)) begin
      code_nx_s = cmd_s2_r;
      case (cmd_s2_r)
        4'b0000, 4'b1000: state_nx_s = IDLE;
        4'b0100: begin state_nx_s = LATCH; do_latch_s = 1'b1; end
        4'b0010: begin state_nx_s = WRITE; do_write_s = 1'b1; end
        4'b0001: state_nx_s = READ;
        default: begin state_nx_s = IDLE; err_s = 1'b1; end
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // Latch selection, masked write value and read mux with I/O port bypass
  always_comb begin
    sel_ok_s = (!ADDR_CHECK) || (da_s2_r[7:4] == CHIP_ID);
    wr_val_s = da_s2_r & reg_mask(reg_addr_r);
    case (reg_addr_r)
      4'd14:   rd_val_s = regs_r[7][6] ? regs_r[14] : ioa_s2_r;
      4'd15:   rd_val_s = regs_r[7][7] ? regs_r[15] : iob_s2_r;
      default: rd_val_s = regs_r[reg_addr_r];
    endcase
  end

  // Register file, address latch and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs_r[i] <= 8'h00;
      reg_addr_r    <= 4'h0;
      selected_r    <= 1'b1;
      da_out_r      <= 8'h00;
      da_oe_r       <= 1'b0;
      wr_strobe_r   <= 1'b0;
      wr_data_r     <= 8'h00;
      env_restart_r <= 1'b0;
      cmd_err_r     <= 1'b0;
    end else begin
      wr_strobe_r   <= 1'b0;
      env_restart_r <= 1'b0;
      cmd_err_r     <= err_s;
      if (do_latch_s) begin
        if (sel_ok_s) begin
          selected_r <= 1'b1;
          reg_addr_r <= da_s2_r[3:0];
        end else begin
          selected_r <= 1'b0;
        end
      end
      if (do_write_s && selected_r) begin
        regs_r[reg_addr_r] <= wr_val_s;
        wr_data_r          <= wr_val_s;
        wr_strobe_r        <= 1'b1;
        env_restart_r      <= (reg_addr_r == 4'd13);
      end
      if ((state_nx_s == READ) && selected_r) begin
        da_oe_r  <= 1'b1;
        da_out_r <= rd_val_s;
      end else begin
        da_oe_r  <= 1'b0;
        da_out_r <= 8'h00;
      end
    end
  end

  assign bus.da_out      = da_out_r;
  assign bus.da_oe       = da_oe_r;
  assign bus.reg_addr    = reg_addr_r;
  assign bus.selected    = selected_r;
  assign bus.wr_strobe   = wr_strobe_r;
  assign bus.wr_data     = wr_data_r;
  assign bus.env_restart = env_restart_r;
  assign bus.ioa_out     = regs_r[14];
  assign bus.iob_out     = regs_r[15];
  assign bus.ioa_oe      = regs_r[7][6];
  assign bus.iob_oe      = regs_r[7][7];
  assign bus.cmd_err     = cmd_err_r;

endmodule
